// File: rtl/alarm_timer_pkg.sv
// Shared register map, CTRL bit positions and state encoding for alarm_timer.
package alarm_timer_pkg;

    localparam logic [1:0] ADDR_RELOAD = 2'd0;
    localparam logic [1:0] ADDR_CTRL   = 2'd1;
    localparam logic [1:0] ADDR_STOP   = 2'd2;

    localparam int CTRL_START = 0;
    localparam int CTRL_AUTO  = 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FIRED = 2'd2
    } state_e;

endpackage

// File: rtl/alarm_prescaler.sv
// Divides clk by PRESCALE into a one-cycle tick; counts only while enabled.
module alarm_prescaler #(
    parameter int PRESCALE = 90000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(PRESCALE - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign tick = enable && (cnt_q == LAST);

    // NOTE: every always_comb output gets a default first, so no latch is inferred.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/alarm_timer.sv
// CPU-programmable countdown/alarm timer with level irq and ack handshake.
// Optional missed-interrupt counter enabled by defining ALARM_TIMER_MISS_CNT_EN.
module alarm_timer
    import alarm_timer_pkg::*;
#(
    parameter int PRESCALE = 90000,
    parameter int WIDTH    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [1:0]       wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             irq_ack,
    output logic             irq,
    output logic             busy,
`ifdef ALARM_TIMER_MISS_CNT_EN
    output logic [WIDTH-1:0] count,
    output logic [7:0]       miss_cnt
`else
    output logic [WIDTH-1:0] count
`endif
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             auto_q, auto_d;
    logic             irq_q, irq_d;
    logic             busy_q, busy_d;

    logic wr_reload, wr_ctrl, wr_stop, start, pre_en, tick, expire;

    assign wr_reload = wr_en && (wr_addr == ADDR_RELOAD);
    assign wr_ctrl   = wr_en && (wr_addr == ADDR_CTRL);
    assign wr_stop   = wr_en && (wr_addr == ADDR_STOP);
    assign start     = wr_ctrl && wr_data[CTRL_START];

    // A start or STOP in a tick cycle overrides that tick, so the prescaler is held off.
    assign pre_en = (state_q == RUN) && !start && !wr_stop;
    assign expire = tick && (count_q == WIDTH'(1));

    alarm_prescaler #(
        .PRESCALE(PRESCALE)
    ) u_prescaler (
        .clk   (clk),
        .rst   (rst),
        .clear (start),
        .enable(pre_en),
        .tick  (tick)
    );

    always_comb begin
        state_d  = state_q;
        reload_d = reload_q;
        count_d  = count_q;
        auto_d   = auto_q;
        irq_d    = irq_q;

        if (irq_ack) irq_d = 1'b0;
        if (wr_reload) reload_d = wr_data;
        if (wr_ctrl) auto_d = wr_data[CTRL_AUTO];

        if (start) begin
            count_d = reload_q;
            if (reload_q == '0) begin
                state_d = FIRED;
                irq_d   = 1'b1;
            end else begin
                state_d = RUN;
            end
        end else if (wr_stop) begin
            state_d = IDLE;
        end else if (expire) begin
            irq_d = 1'b1;
            if (auto_q && (reload_q != '0)) begin
                count_d = reload_q;
            end else begin
                count_d = '0;
                state_d = FIRED;
            end
        end else if (tick) begin
            count_d = count_q - WIDTH'(1);
        end

        busy_d = (state_d == RUN);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            reload_q <= '0;
            count_q  <= '0;
            auto_q   <= 1'b0;
            irq_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            reload_q <= reload_d;
            count_q  <= count_d;
            auto_q   <= auto_d;
            irq_q    <= irq_d;
            busy_q   <= busy_d;
        end
    end

    assign irq   = irq_q;
    assign busy  = busy_q;
    assign count = count_q;

`ifdef ALARM_TIMER_MISS_CNT_EN
    logic [7:0] miss_q, miss_d;

    // A miss is an expiry landing on an irq the CPU has not yet acknowledged.
    always_comb begin
        miss_d = miss_q;
        if (start) begin
            miss_d = '0;
        end else if (expire && irq_q && !irq_ack && (miss_q != 8'hFF)) begin
            miss_d = miss_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            miss_q <= '0;
        end else begin
            miss_q <= miss_d;
        end
    end

    assign miss_cnt = miss_q;
`endif

endmodule

// File: tb/tb_alarm_timer.sv
// Directed, table-driven bench for alarm_timer with PRESCALE = 4.
module tb_alarm_timer;

    localparam int PRESCALE = 4;
    localparam int WIDTH    = 16;
    localparam int NVEC     = 21;

    logic             clk;
    logic             rst;
    logic             wr_en;
    logic [1:0]       wr_addr;
    logic [WIDTH-1:0] wr_data;
    logic             irq_ack;
    logic             irq;
    logic             busy;
    logic [WIDTH-1:0] count;
`ifdef ALARM_TIMER_MISS_CNT_EN
    logic [7:0]       miss_cnt;
`endif

    int checks = 0;
    int errors = 0;

    alarm_timer #(
        .PRESCALE(PRESCALE),
        .WIDTH   (WIDTH)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .irq_ack (irq_ack),
        .irq     (irq),
        .busy    (busy),
`ifdef ALARM_TIMER_MISS_CNT_EN
        .count   (count),
        .miss_cnt(miss_cnt)
`else
        .count   (count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic             we;
        logic [1:0]       addr;
        logic [WIDTH-1:0] data;
        logic             ack;
        int               idle;
        logic [WIDTH-1:0] exp_count;
        logic             exp_irq;
        logic             exp_busy;
    } vec_t;

    vec_t vecs [NVEC];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic write(input logic [1:0] addr, input logic [WIDTH-1:0] data);
        wr_en   = 1'b1;
        wr_addr = addr;
        wr_data = data;
        cyc(1);
        wr_en   = 1'b0;
        wr_addr = 2'd3;
        wr_data = '0;
    endtask

    task automatic check_state(input string tag, input logic [WIDTH-1:0] c, input logic i, input logic b);
        check({tag, " count"}, 32'(count), 32'(c));
        check({tag, " irq"},   32'(irq),   32'(i));
        check({tag, " busy"},  32'(busy),  32'(b));
    endtask

    initial begin
        // Edge numbers in comments count from the edge that accepted start.
        //             we    addr  data      ack   idle cnt  irq   busy
        vecs[0]  = '{1'b1, 2'd0, 16'd3,    1'b0, 0,  16'd0, 1'b0, 1'b0}; // RELOAD=3
        vecs[1]  = '{1'b1, 2'd1, 16'h1,    1'b0, 0,  16'd3, 1'b0, 1'b1}; // start, E0
        vecs[2]  = '{1'b0, 2'd3, 16'h0,    1'b0, 2,  16'd3, 1'b0, 1'b1}; // E3
        vecs[3]  = '{1'b0, 2'd3, 16'h0,    1'b0, 0,  16'd2, 1'b0, 1'b1}; // E4
        vecs[4]  = '{1'b0, 2'd3, 16'h0,    1'b0, 6,  16'd1, 1'b0, 1'b1}; // E11
        vecs[5]  = '{1'b0, 2'd3, 16'h0,    1'b0, 0,  16'd0, 1'b1, 1'b0}; // E12 expiry
        vecs[6]  = '{1'b0, 2'd3, 16'h0,    1'b0, 4,  16'd0, 1'b1, 1'b0}; // irq held
        vecs[7]  = '{1'b0, 2'd3, 16'h0,    1'b1, 0,  16'd0, 1'b0, 1'b0}; // ack
        vecs[8]  = '{1'b0, 2'd3, 16'h0,    1'b1, 0,  16'd0, 1'b0, 1'b0}; // ack, no irq
        vecs[9]  = '{1'b1, 2'd0, 16'd0,    1'b0, 0,  16'd0, 1'b0, 1'b0}; // RELOAD=0
        vecs[10] = '{1'b1, 2'd1, 16'h1,    1'b0, 0,  16'd0, 1'b1, 1'b0}; // zero-load start
        vecs[11] = '{1'b0, 2'd3, 16'h0,    1'b1, 0,  16'd0, 1'b0, 1'b0}; // ack
        vecs[12] = '{1'b1, 2'd0, 16'd5,    1'b0, 0,  16'd0, 1'b0, 1'b0}; // RELOAD=5
        vecs[13] = '{1'b1, 2'd1, 16'h1,    1'b0, 0,  16'd5, 1'b0, 1'b1}; // start, E0
        vecs[14] = '{1'b0, 2'd3, 16'h0,    1'b0, 7,  16'd3, 1'b0, 1'b1}; // E8
        vecs[15] = '{1'b1, 2'd2, 16'hFFFF, 1'b0, 0,  16'd3, 1'b0, 1'b0}; // STOP at E9
        vecs[16] = '{1'b0, 2'd3, 16'h0,    1'b0, 10, 16'd3, 1'b0, 1'b0}; // frozen
        vecs[17] = '{1'b1, 2'd1, 16'h1,    1'b0, 0,  16'd5, 1'b0, 1'b1}; // restart, E0
        vecs[18] = '{1'b0, 2'd3, 16'h0,    1'b0, 18, 16'd1, 1'b0, 1'b1}; // E19
        vecs[19] = '{1'b0, 2'd3, 16'h0,    1'b0, 0,  16'd0, 1'b1, 1'b0}; // E20 expiry
        vecs[20] = '{1'b0, 2'd3, 16'h0,    1'b1, 0,  16'd0, 1'b0, 1'b0}; // ack

        rst     = 1'b1;
        wr_en   = 1'b0;
        wr_addr = 2'd3;
        wr_data = '0;
        irq_ack = 1'b0;
        cyc(3);
        check_state("reset", 16'd0, 1'b0, 1'b0);
        rst = 1'b0;
        cyc(2);
        check_state("post_reset", 16'd0, 1'b0, 1'b0);

        for (int v = 0; v < NVEC; v++) begin
            wr_en   = vecs[v].we;
            wr_addr = vecs[v].addr;
            wr_data = vecs[v].data;
            irq_ack = vecs[v].ack;
            cyc(1);
            wr_en   = 1'b0;
            wr_addr = 2'd3;
            wr_data = '0;
            irq_ack = 1'b0;
            if (vecs[v].idle > 0) cyc(vecs[v].idle);
            check_state($sformatf("vec%0d", v), vecs[v].exp_count, vecs[v].exp_irq, vecs[v].exp_busy);
        end

        // Autoreload: RELOAD=2, CTRL=start|auto; expiries every 8 cycles.
        write(2'd0, 16'd2);
        write(2'd1, 16'h3);
        check_state("auto_E0", 16'd2, 1'b0, 1'b1);
`ifdef ALARM_TIMER_MISS_CNT_EN
        check("auto_E0 miss", 32'(miss_cnt), 32'd0);
`endif
        cyc(7);
        check_state("auto_E7", 16'd1, 1'b0, 1'b1);
        cyc(1);
        check_state("auto_E8", 16'd2, 1'b1, 1'b1);
        cyc(8);
        check_state("auto_E16", 16'd2, 1'b1, 1'b1);
`ifdef ALARM_TIMER_MISS_CNT_EN
        check("auto_E16 miss", 32'(miss_cnt), 32'd1);
`endif
        cyc(8);
        check_state("auto_E24", 16'd2, 1'b1, 1'b1);
`ifdef ALARM_TIMER_MISS_CNT_EN
        check("auto_E24 miss", 32'(miss_cnt), 32'd2);
`endif

        // Ack lands on the E32 expiry: expiry wins, and it is not counted as a miss.
        cyc(7);
        irq_ack = 1'b1;
        cyc(1);
        irq_ack = 1'b0;
        check_state("collide_E32", 16'd2, 1'b1, 1'b1);
`ifdef ALARM_TIMER_MISS_CNT_EN
        check("collide_E32 miss", 32'(miss_cnt), 32'd2);
`endif
        irq_ack = 1'b1;
        cyc(1);
        irq_ack = 1'b0;
        check("ack_E33 irq", 32'(irq), 32'd0);
        cyc(7);
        check_state("auto_E40", 16'd2, 1'b1, 1'b1);
`ifdef ALARM_TIMER_MISS_CNT_EN
        check("auto_E40 miss", 32'(miss_cnt), 32'd2);
`endif

        // Asynchronous reset mid-count with count == 2.
        cyc(1);
        check("pre_rst count", 32'(count), 32'd2);
        rst = 1'b1;
        #1;
        check_state("rst_async", 16'd0, 1'b0, 1'b0);
`ifdef ALARM_TIMER_MISS_CNT_EN
        check("rst_async miss", 32'(miss_cnt), 32'd0);
`endif
        cyc(2);
        rst = 1'b0;
        cyc(30);
        check_state("after_rst", 16'd0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
